// File: rtl/nn_layer_engine.sv
// ---------------------------------------------------------------------------
// nn_layer_engine
//
// Purpose:
//   Computes one fully connected 8-bit layer out of a shared byte-wide RAM.
//   For each output neuron j, every x[i]*w[j][i] product is accumulated in a
//   32-bit signed register. The sum then goes through ReLU, an arithmetic
//   right shift by SHIFT, and saturation to 0..127. The result is written
//   back to OUT_BASE + j.
//
// Ports:
//   clk            single clock, rising edge
//   reset          synchronous, active-low reset
//   run_inference  start request (pulse or level); accepted in IDLE/DONE only
//   ready          high while in DONE (result available)
//   busy           high while a layer is being computed
//   nn_address     byte address to shared RAM port 1
//   nn_wd          write data to shared RAM port 1
//   nn_we          write enable to shared RAM port 1
//   nn_rd          read data from RAM port 1, valid one cycle after address
//
// All outputs are registers. Each output is loaded with the value that
// belongs to the state being entered, so it lines up with that state.
// ---------------------------------------------------------------------------
module nn_layer_engine #(
  parameter int         N_IN     = 16,
  parameter int         N_OUT    = 4,
  parameter logic [9:0] IN_BASE  = 10'h000,
  parameter logic [9:0] W_BASE   = 10'h010,
  parameter logic [9:0] OUT_BASE = 10'h3F0,
  parameter int         SHIFT    = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run_inference,
  output logic       ready,
  output logic       busy,
  output logic [9:0] nn_address,
  output logic [7:0] nn_wd,
  output logic       nn_we,
  input  logic [7:0] nn_rd
);

  typedef enum logic [2:0] {IDLE, RD_X, RD_W, MAC, WR, DONE} state_t;

  localparam logic [8:0]  I_LAST   = 9'(N_IN - 1);
  localparam logic [6:0]  J_LAST   = 7'(N_OUT - 1);
  localparam logic [31:0] N_IN_U   = 32'(N_IN);

  state_t             state_reg;
  logic [8:0]         i_reg;
  logic [6:0]         j_reg;
  logic signed [31:0] acc_reg;
  logic [7:0]         x_q_reg;
  logic               ready_reg;
  logic               busy_reg;
  logic [9:0]         addr_reg;
  logic [7:0]         wd_reg;
  logic               we_reg;

  // Datapath helpers (combinational, feed registers only)
  logic signed [15:0] prod_next;
  logic signed [31:0] acc_next;
  logic [8:0]         i_inc_next;
  logic [9:0]         w_off_next;
  logic [9:0]         x_addr_next;
  logic [9:0]         w_addr_next;
  logic [9:0]         o_addr_next;

  assign prod_next   = $signed(x_q_reg) * $signed(nn_rd);
  assign acc_next    = acc_reg + {{16{prod_next[15]}}, prod_next};
  assign i_inc_next  = i_reg + 9'd1;
  // Addresses wrap modulo 1024 by truncation to 10 bits
  assign w_off_next  = 10'(32'(j_reg) * N_IN_U + 32'(i_reg));
  assign x_addr_next = IN_BASE + 10'(i_inc_next);
  assign w_addr_next = W_BASE + w_off_next;
  assign o_addr_next = OUT_BASE + 10'(j_reg);

  // ReLU, then arithmetic shift, then clamp to the positive int8 range
  function automatic logic [7:0] relu_sat(input logic signed [31:0] a);
    logic signed [31:0] s;
    logic [7:0]         r;
    s = a >>> SHIFT;
    if (a < 0)
      r = 8'h00;
    else if (s > 32'sd127)
      r = 8'h7F;
    else
      r = 8'(s);
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= IDLE;
      i_reg     <= '0;
      j_reg     <= '0;
      acc_reg   <= '0;
      x_q_reg   <= '0;
      ready_reg <= 1'b0;
      busy_reg  <= 1'b0;
      addr_reg  <= '0;
      wd_reg    <= '0;
      we_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          // Restart is level-sensitive here; a request is ignored elsewhere
          if (run_inference) begin
            state_reg <= RD_X;
            i_reg     <= '0;
            j_reg     <= '0;
            acc_reg   <= '0;
            ready_reg <= 1'b0;
            busy_reg  <= 1'b1;
            addr_reg  <= IN_BASE;
            wd_reg    <= '0;
            we_reg    <= 1'b0;
          end
        end
        RD_X: begin
          state_reg <= RD_W;
          addr_reg  <= w_addr_next;
        end
        RD_W: begin
          // nn_rd now carries x[i], requested during RD_X
          x_q_reg   <= nn_rd;
          state_reg <= MAC;
        end
        MAC: begin
          // nn_rd now carries w[j][i], requested during RD_W
          acc_reg <= acc_next;
          if (i_reg < I_LAST) begin
            i_reg     <= i_inc_next;
            state_reg <= RD_X;
            addr_reg  <= x_addr_next;
          end else begin
            state_reg <= WR;
            addr_reg  <= o_addr_next;
            wd_reg    <= relu_sat(acc_next);
            we_reg    <= 1'b1;
          end
        end
        WR: begin
          we_reg <= 1'b0;
          wd_reg <= '0;
          if (j_reg < J_LAST) begin
            j_reg     <= j_reg + 7'd1;
            i_reg     <= '0;
            acc_reg   <= '0;
            state_reg <= RD_X;
            addr_reg  <= IN_BASE;
          end else begin
            state_reg <= DONE;
            busy_reg  <= 1'b0;
            ready_reg <= 1'b1;
            addr_reg  <= '0;
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
          ready_reg <= 1'b0;
          addr_reg  <= '0;
          wd_reg    <= '0;
          we_reg    <= 1'b0;
        end
      endcase
    end
  end

  assign ready      = ready_reg;
  assign busy       = busy_reg;
  assign nn_address = addr_reg;
  assign nn_wd      = wd_reg;
  assign nn_we      = we_reg;

endmodule

// File: tb/tb_nn_layer_engine.sv
module tb_nn_layer_engine;

  localparam int N_IN     = 16;
  localparam int N_OUT    = 4;
  localparam int SHIFT    = 7;
  localparam int IN_BASE  = 'h000;
  localparam int W_BASE   = 'h010;
  localparam int OUT_BASE = 'h3F0;
  localparam int LAT      = N_OUT * (3 * N_IN + 1) + 1;  // first ready cycle

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       run_inference = 1'b0;
  logic       ready, busy, nn_we;
  logic [9:0] nn_address;
  logic [7:0] nn_wd;
  logic [7:0] nn_rd = 8'h00;

  // RAM contents: inputs/weights owned by the stimulus, outputs by the RAM
  logic [7:0] xs [N_IN];
  logic [7:0] ws [N_IN*N_OUT];
  logic [7:0] ys [N_OUT];
  logic       clr_out = 1'b0;
  int         we_count = 0;
  int         bad_writes = 0;

  int checks = 0;
  int errors = 0;

  nn_layer_engine dut (
    .clk           (clk),
    .reset         (reset),
    .run_inference (run_inference),
    .ready         (ready),
    .busy          (busy),
    .nn_address    (nn_address),
    .nn_wd         (nn_wd),
    .nn_we         (nn_we),
    .nn_rd         (nn_rd)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ram_read(input logic [9:0] a);
    int ai;
    ai = int'(a);
    if (ai >= IN_BASE && ai < IN_BASE + N_IN) return xs[ai - IN_BASE];
    if (ai >= W_BASE && ai < W_BASE + N_IN*N_OUT) return ws[ai - W_BASE];
    if (ai >= OUT_BASE && ai < OUT_BASE + N_OUT) return ys[ai - OUT_BASE];
    return 8'h00;
  endfunction

  // Synchronous RAM port with 1-cycle read latency
  always @(posedge clk) begin
    if (clr_out) begin
      for (int k = 0; k < N_OUT; k++) ys[k] <= 8'hAA;
    end else if (nn_we) begin
      we_count++;
      if (int'(nn_address) >= OUT_BASE && int'(nn_address) < OUT_BASE + N_OUT)
        ys[int'(nn_address) - OUT_BASE] <= nn_wd;
      else
        bad_writes++;
    end
    nn_rd <= ram_read(nn_address);
  end

  // Reference: dot product, ReLU, shift, clamp
  function automatic logic [7:0] model_y(input int j);
    int acc;
    acc = 0;
    for (int i = 0; i < N_IN; i++)
      acc += int'($signed(xs[i])) * int'($signed(ws[j*N_IN + i]));
    if (acc < 0) return 8'h00;
    acc = acc / (1 << SHIFT);
    if (acc > 127) return 8'h7F;
    return 8'(acc);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic fill(input int mode, input logic [7:0] xv, input logic [7:0] wv);
    for (int i = 0; i < N_IN; i++) xs[i] = (mode == 0) ? xv : 8'($urandom_range(0, 255));
    for (int k = 0; k < N_IN*N_OUT; k++) ws[k] = (mode == 0) ? wv : 8'($urandom_range(0, 255));
  endtask

  task automatic clear_outputs();
    clr_out = 1'b1;
    @(posedge clk); #1;
    clr_out = 1'b0;
  endtask

  // Pulse run_inference for one edge; returns with cycle number 1
  task automatic start_run(output int cyc);
    run_inference = 1'b1;
    @(posedge clk); #1;
    run_inference = 1'b0;
    cyc = 1;
  endtask

  task automatic wait_ready(inout int cyc);
    while (ready !== 1'b1 && cyc < 1000) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic check_result(input string tag, input int cyc, input int wc0,
                              input bit use_const, input logic [7:0] cval);
    logic [7:0] e;
    chk({tag, " latency"}, 32'(cyc), 32'(LAT));
    chk({tag, " we_pulses"}, 32'(we_count - wc0), 32'(N_OUT));
    chk({tag, " stray_writes"}, 32'(bad_writes), 32'd0);
    chk({tag, " done_busy"}, 32'(busy), 32'd0);
    chk({tag, " done_addr"}, 32'(nn_address), 32'd0);
    chk({tag, " done_wd"}, 32'(nn_wd), 32'd0);
    chk({tag, " done_we"}, 32'(nn_we), 32'd0);
    for (int j = 0; j < N_OUT; j++) begin
      e = use_const ? cval : model_y(j);
      chk($sformatf("%s y[%0d]", tag, j), 32'(ys[j]), 32'(e));
    end
    $display("run %-10s latency=%0d y=%02h %02h %02h %02h", tag, cyc,
             ys[0], ys[1], ys[2], ys[3]);
  endtask

  task automatic full_run(input string tag, input bit use_const, input logic [7:0] cval);
    int cyc, wc0;
    clear_outputs();
    wc0 = we_count;
    start_run(cyc);
    chk({tag, " busy_c1"}, 32'(busy), 32'd1);
    chk({tag, " ready_c1"}, 32'(ready), 32'd0);
    wait_ready(cyc);
    check_result(tag, cyc, wc0, use_const, cval);
  endtask

  initial begin
    int cyc, wc0;

    // Reset held for two cycles with a competing start request
    reset = 1'b0;
    run_inference = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset ready", 32'(ready), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset we", 32'(nn_we), 32'd0);
    chk("reset addr", 32'(nn_address), 32'd0);
    chk("reset wd", 32'(nn_wd), 32'd0);
    run_inference = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("idle busy", 32'(busy), 32'd0);

    // Directed value patterns
    fill(0, 8'h10, 8'h10); full_run("x10w10", 1'b1, 8'h20);
    fill(0, 8'h10, 8'hF0); full_run("relu", 1'b1, 8'h00);
    fill(0, 8'h7F, 8'h7F); full_run("saturate", 1'b1, 8'h7F);
    fill(0, 8'h80, 8'h80); full_run("neg_x_neg", 1'b1, 8'h7F);

    // Randomized data against the reference model
    for (int r = 0; r < 4; r++) begin
      fill(1, 8'h00, 8'h00);
      full_run($sformatf("rand%0d", r), 1'b0, 8'h00);
    end

    // Start request mid-run is ignored
    fill(1, 8'h00, 8'h00);
    clear_outputs();
    wc0 = we_count;
    start_run(cyc);
    while (cyc < 49) begin @(posedge clk); #1; cyc++; end
    run_inference = 1'b1;
    @(posedge clk); #1; cyc++;
    run_inference = 1'b0;
    chk("busy_pulse busy", 32'(busy), 32'd1);
    wait_ready(cyc);
    check_result("busy_pulse", cyc, wc0, 1'b0, 8'h00);

    // Second start from DONE with new data
    fill(1, 8'h00, 8'h00);
    clear_outputs();
    chk("done_hold ready", 32'(ready), 32'd1);
    wc0 = we_count;
    start_run(cyc);
    chk("restart ready_drop", 32'(ready), 32'd0);
    chk("restart busy", 32'(busy), 32'd1);
    wait_ready(cyc);
    check_result("restart", cyc, wc0, 1'b0, 8'h00);

    // Level-held request restarts at the first DONE edge
    fill(1, 8'h00, 8'h00);
    clear_outputs();
    wc0 = we_count;
    run_inference = 1'b1;
    @(posedge clk); #1;
    cyc = 1;
    wait_ready(cyc);
    chk("level latency", 32'(cyc), 32'(LAT));
    @(posedge clk); #1;
    chk("level ready", 32'(ready), 32'd0);
    chk("level busy", 32'(busy), 32'd1);
    run_inference = 1'b0;
    cyc = 1;
    wait_ready(cyc);
    chk("level second_done", 32'(ready), 32'd1);
    chk("level we_pulses", 32'(we_count - wc0), 32'(2 * N_OUT));

    // Reset in the middle of a run
    fill(1, 8'h00, 8'h00);
    clear_outputs();
    wc0 = we_count;
    start_run(cyc);
    while (cyc < 100) begin @(posedge clk); #1; cyc++; end
    reset = 1'b0;
    @(posedge clk); #1;
    chk("midreset busy", 32'(busy), 32'd0);
    chk("midreset ready", 32'(ready), 32'd0);
    chk("midreset we", 32'(nn_we), 32'd0);
    chk("midreset addr", 32'(nn_address), 32'd0);
    chk("midreset writes", 32'(we_count - wc0), 32'd2);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("midreset quiet", 32'(we_count - wc0), 32'd2);
    chk("midreset idle_ready", 32'(ready), 32'd0);
    chk("midreset idle_busy", 32'(busy), 32'd0);
    full_run("post_reset", 1'b0, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/nn_layer_engine.md
NN_LAYER_ENGINE -- requirements
Module: nn_layer_engine

Interface
REQ-001: Parameter N_IN, default 16, inputs per neuron; legal range 1..256.
REQ-002: Parameter N_OUT, default 4, output neurons; legal range 1..64.
REQ-003: Parameter IN_BASE, default 10'h000, byte address of input vector x[0..N_IN-1].
REQ-004: Parameter W_BASE, default 10'h010, byte address of weight matrix, row-major, w[j][i] at W_BASE + j*N_IN + i.
REQ-005: Parameter OUT_BASE, default 10'h3F0, byte address of output vector y[0..N_OUT-1].
REQ-006: Parameter SHIFT, default 7, right-shift applied to accumulator before saturation; legal range 0..24.
REQ-007: clk  input  1  single clock; all state changes on rising edge.
REQ-008: reset  input  1  synchronous, active-low reset (0 = reset), sampled on rising clk.
REQ-009: run_inference  input  1  start request from the CPU, one-cycle pulse or level.
REQ-010: ready  output  1  inference-complete flag, level, to the CPU interrupt pulse generator.
REQ-011: busy  output  1  high while a layer computation is in progress.
REQ-012: nn_address  output  10  byte address into shared RAM port 1.
REQ-013: nn_wd  output  8  write data to shared RAM port 1.
REQ-014: nn_we  output  1  write enable to shared RAM port 1.
REQ-015: nn_rd  input  8  read data from shared RAM port 1; valid the cycle after address is presented (1-cycle read latency).

Function
REQ-016: States SHALL be IDLE, RD_X, RD_W, MAC, WR, DONE; all outputs are decoded from registered state/data only; no combinational path from run_inference or nn_rd to any output.
REQ-017: IDLE or DONE with run_inference=1 at a rising edge SHALL go to RD_X with j=0, i=0, acc=0; otherwise the state holds.
REQ-018: RD_X SHALL drive nn_address = IN_BASE + i, then go to RD_W.
REQ-019: RD_W SHALL drive nn_address = W_BASE + j*N_IN + i, capture x_q <= nn_rd, then go to MAC.
REQ-020: MAC SHALL compute acc <= acc + signed(x_q) * signed(nn_rd) (8x8 signed, 16-bit product, 32-bit signed acc); if i < N_IN-1, i++ and go to RD_X, else go to WR.
REQ-021: WR SHALL drive nn_address = OUT_BASE + j, nn_we=1, nn_wd = sat(relu(acc) >>> SHIFT): acc<0 -> 0; shifted value >127 -> 8'h7F; else low 8 bits.
REQ-022: WR, if j < N_OUT-1: j++, i=0, acc=0, go to RD_X; else go to DONE.
REQ-023: All address sums SHALL wrap modulo 1024.
REQ-024: nn_we SHALL be 1 only in WR; nn_address=0 and nn_wd=0 in IDLE and DONE.
REQ-025: busy SHALL be 1 in RD_X, RD_W, MAC, WR; 0 in IDLE and DONE.
REQ-026: ready SHALL be 1 exactly in DONE; it holds until the next accepted run_inference, then drops in the following cycle.
REQ-027: Latency: with run_inference sampled at edge of cycle 0, last WR occurs in cycle N_OUT*(3*N_IN+1) and ready=1 from cycle N_OUT*(3*N_IN+1)+1 (defaults: 196 / 197).
REQ-028: run_inference while busy=1 SHALL be ignored with no effect on state, counters, or acc.
REQ-029: run_inference held high across DONE SHALL start a new inference at the first DONE edge (restart is level-sensitive in IDLE/DONE).

Reset
REQ-030: reset=0 at a rising edge SHALL force IDLE, i=0, j=0, acc=0, x_q=0, ready=0, busy=0, nn_we=0, nn_address=0, nn_wd=0, regardless of state, including mid-inference.
REQ-031: reset SHALL take priority over run_inference in the same cycle; no RAM write occurs in the cycle after reset assertion.

Verification
REQ-032: Reset: reset=0 for 2 cycles in any state -> ready=0, busy=0, nn_we=0, nn_address=0 next cycle.
REQ-033: Defaults, all x=8'h10, all w=8'h10, pulse run_inference -> y[0..3]=8'h20 at 0x3F0..0x3F3; exactly 4 nn_we pulses; ready rises in cycle 197.
REQ-034: x=8'h10, w=8'hF0 (-16) -> acc=-4096, y[0..3]=8'h00 (ReLU).
REQ-035: x=8'h7F, w=8'h7F -> acc=258064, >>>7 = 2016, y[0..3]=8'h7F (saturation).
REQ-036: run_inference pulsed at cycle 50 of a busy run -> no restart, ready still rises in cycle 197; second pulse in DONE -> ready=0 next cycle, new result written.
REQ-037: reset=0 in cycle 100 of a run -> IDLE next cycle, no further nn_we, ready=0; fresh run_inference afterwards completes normally with correct y.
